// File: rtl/phrase_ram_ctrl_if.sv
// Bus bundle for the phrase RAM controller: host commands, phrase byte
// stream, video and host read ports, and the RAM-facing signals.
// The master side is the host/video/RAM environment; the slave side is the controller.
interface phrase_ram_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  // host command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  // phrase byte stream
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  // status
  logic              busy;
  logic              done;
  // video read port
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_data_valid;
  logic [DATA_W-1:0] vid_data;
  // host readback port
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_grant;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  // RAM side
  logic              ram_enable;
  logic              ram_write_enable;
  logic [ADDR_W-1:0] ram_address_wr;
  logic [ADDR_W-1:0] ram_address_rd;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output vid_req, vid_addr,
    output rd_req, rd_addr,
    output ram_data_out,
    input  cmd_ready, wr_ready, busy, done,
    input  vid_data_valid, vid_data,
    input  rd_grant, rd_data_valid, rd_data,
    input  ram_enable, ram_write_enable, ram_address_wr, ram_address_rd, ram_data_in
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  vid_req, vid_addr,
    input  rd_req, rd_addr,
    input  ram_data_out,
    output cmd_ready, wr_ready, busy, done,
    output vid_data_valid, vid_data,
    output rd_grant, rd_data_valid, rd_data,
    output ram_enable, ram_write_enable, ram_address_wr, ram_address_rd, ram_data_in
  );
endinterface

// File: rtl/phrase_ram_ctrl.sv
// Phrase RAM controller: streams host phrases or clears address ranges into
// the 8192x8 phrase RAM, and arbitrates its read port between video
// character fetch (always served) and host readback (served when video idle).
module phrase_ram_ctrl #(
  parameter int                ADDR_W      = 13,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
  input logic              clock,
  input logic              reset_n,
  phrase_ram_ctrl_if.slave bus
);

  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              done_q;
  logic              take_cmd;
  logic              write_fire;
  logic              last_one;

  logic              vid_sel;
  logic              rd_sel;
  logic [ADDR_W-1:0] rd_address;
  logic [ADDR_W-1:0] rd_addr_hold;
  logic              vid_vld_p1;
  logic              rd_vld_p1;

  assign last_one = (remaining == LEN_W'(1));

  // Command FSM register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus per-cycle write strobe
  always_comb begin
    state_d    = state_q;
    take_cmd   = 1'b0;
    write_fire = 1'b0;
    case (state_q)
      IDLE: begin
        take_cmd = bus.cmd_valid;
        if (bus.cmd_valid && (bus.cmd_len != '0)) begin
          state_d = bus.cmd_op ? CLEAR : WRITE;
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          write_fire = 1'b1;
          if (last_one) begin
            state_d = IDLE;
          end
        end
      end
      CLEAR: begin
        write_fire = 1'b1;
        if (last_one) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address/count tracking and the completion pulse; a zero-length command
  // completes straight from IDLE without touching the RAM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (take_cmd && (bus.cmd_len == '0)) || (write_fire && last_one);
      if (take_cmd) begin
        cur_addr  <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (write_fire) begin
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  // Read arbitration: video wins, host waits; the address holds when idle.
  // Requests are ignored while reset is asserted so the RAM stays disabled.
  always_comb begin
    vid_sel    = reset_n & bus.vid_req;
    rd_sel     = reset_n & bus.rd_req & ~bus.vid_req;
    rd_address = rd_addr_hold;
    if (vid_sel) begin
      rd_address = bus.vid_addr;
    end else if (rd_sel) begin
      rd_address = bus.rd_addr;
    end
  end

  // Read issue -> return stage: valids follow the RAM's one-cycle latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_hold <= '0;
      vid_vld_p1   <= 1'b0;
      rd_vld_p1    <= 1'b0;
    end else begin
      rd_addr_hold <= rd_address;
      vid_vld_p1   <= vid_sel;
      rd_vld_p1    <= rd_sel;
    end
  end

  assign bus.cmd_ready        = (state_q == IDLE);
  assign bus.wr_ready         = (state_q == WRITE);
  assign bus.busy             = (state_q != IDLE);
  assign bus.done             = done_q;

  assign bus.ram_write_enable = write_fire;
  assign bus.ram_address_wr   = cur_addr;
  assign bus.ram_data_in      = (state_q == CLEAR) ? CLEAR_VALUE : bus.wr_data;
  assign bus.ram_address_rd   = rd_address;
  assign bus.ram_enable       = write_fire | vid_sel | rd_sel;

  assign bus.rd_grant         = rd_sel;
  assign bus.vid_data_valid   = vid_vld_p1;
  assign bus.vid_data         = bus.ram_data_out;
  assign bus.rd_data_valid    = rd_vld_p1;
  assign bus.rd_data          = bus.ram_data_out;

endmodule

// File: tb/tb_phrase_ram_ctrl.sv
// Bench for phrase_ram_ctrl: a RAM model, a scoreboard built from the
// expected sequence of writes per command, and directed plus random traffic.
module tb_phrase_ram_ctrl;

  localparam logic [7:0] CLEAR_VALUE = 8'h00;

  logic clock;
  logic reset_n;
  logic mon_en;
  logic traffic_en;
  int   checks = 0;
  int   errors = 0;

  phrase_ram_ctrl_if #(.ADDR_W(13), .DATA_W(8)) bus ();

  phrase_ram_ctrl #(.ADDR_W(13), .DATA_W(8), .CLEAR_VALUE(CLEAR_VALUE)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM model: registered read of the old byte, enable gates both ports
  logic [7:0] mem [0:8191];
  initial begin : ram_model
    for (int i = 0; i < 8192; i++) mem[i] = pat(i);
    bus.ram_data_out = 8'h00;
    forever begin
      @(posedge clock);
      if (bus.ram_enable) begin
        bus.ram_data_out <= mem[bus.ram_address_rd];
        if (bus.ram_write_enable) mem[bus.ram_address_wr] <= bus.ram_data_in;
      end
    end
  end

  // Scoreboard state
  typedef struct packed { logic [12:0] a; logic [7:0] d; } wr_t;
  wr_t         wq[$];
  logic [7:0]  ref_mem [0:8191];
  logic [7:0]  phrase [0:63];
  logic        done_pend, vid_pend, rd_pend, cur_op, last_grant;
  logic [7:0]  vid_exp, rd_exp;
  logic [12:0] exp_raddr;
  int          vdv_count;

  initial begin : monitor
    wr_t  e;
    logic idle, wr_exp, exp_grant;
    for (int i = 0; i < 8192; i++) ref_mem[i] = pat(i);
    done_pend = 0; vid_pend = 0; rd_pend = 0; cur_op = 0; last_grant = 0;
    vid_exp = 0; rd_exp = 0; exp_raddr = 0; vdv_count = 0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        wq.delete();
        done_pend = 0; vid_pend = 0; rd_pend = 0; exp_raddr = 0; last_grant = 0;
      end else begin
        chk("done", bus.done, done_pend);
        chk("vid_dv", bus.vid_data_valid, vid_pend);
        if (vid_pend) chk("vid_data", bus.vid_data, vid_exp);
        chk("rd_dv", bus.rd_data_valid, rd_pend);
        if (rd_pend) chk("rd_data", bus.rd_data, rd_exp);
        if (bus.vid_data_valid) vdv_count++;
        done_pend = 0;
        idle = (wq.size() == 0);
        chk("busy", bus.busy, !idle);
        chk("cmd_ready", bus.cmd_ready, idle);
        chk("wr_ready", bus.wr_ready, !idle && !cur_op);
        wr_exp = !idle && (cur_op || bus.wr_valid);
        chk("we", bus.ram_write_enable, wr_exp);
        exp_grant = bus.rd_req && !bus.vid_req;
        chk("rd_grant", bus.rd_grant, exp_grant);
        if (bus.vid_req) exp_raddr = bus.vid_addr;
        else if (bus.rd_req) exp_raddr = bus.rd_addr;
        chk("raddr", bus.ram_address_rd, exp_raddr);
        chk("ram_en", bus.ram_enable, wr_exp || bus.vid_req || exp_grant);
        vid_pend = bus.vid_req;
        vid_exp  = ref_mem[bus.vid_addr];
        rd_pend  = exp_grant;
        rd_exp   = ref_mem[bus.rd_addr];
        if (wr_exp) begin
          e = wq.pop_front();
          chk("waddr", bus.ram_address_wr, e.a);
          chk("wdata", bus.ram_data_in, e.d);
          ref_mem[e.a] = e.d;
          if (wq.size() == 0) done_pend = 1;
        end
        if (bus.cmd_valid && idle) begin
          cur_op = bus.cmd_op;
          if (bus.cmd_len == 0) done_pend = 1;
          for (int i = 0; i < int'(bus.cmd_len); i++) begin
            e.a = bus.cmd_addr + 13'(i);
            e.d = bus.cmd_op ? CLEAR_VALUE : phrase[i % 64];
            wq.push_back(e);
          end
        end
        last_grant = bus.rd_grant;
      end
    end
  end

  function automatic logic [12:0] rnd_addr();
    case ($urandom_range(0, 2))
      0:       return 13'(16 + $urandom_range(0, 47));
      1:       return 13'(13'h1FF0 + $urandom_range(0, 15));
      default: return 13'($urandom);
    endcase
  endfunction

  // One clock step; drives random read traffic when enabled
  task automatic tick();
    @(posedge clock);
    #1;
    if (traffic_en) begin
      bus.vid_req  = ($urandom_range(0, 2) == 0);
      bus.vid_addr = rnd_addr();
      if (!bus.rd_req || last_grant) begin
        bus.rd_req  = $urandom_range(0, 1) == 1;
        bus.rd_addr = rnd_addr();
      end
    end
  endtask

  task automatic traffic_off();
    traffic_en  = 0;
    bus.vid_req = 0;
    bus.rd_req  = 0;
  endtask

  task automatic issue_cmd(input logic op, input logic [12:0] a, input logic [13:0] len,
                           output int waited);
    logic acc;
    acc = 0;
    waited = 0;
    bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_len = len;
    for (int k = 0; k < 20000 && !acc; k++) begin
      @(negedge clock);
      acc = bus.cmd_ready;
      if (!acc) waited++;
      tick();
    end
    bus.cmd_valid = 0;
    chk("cmd_accept", acc, 1);
  endtask

  task automatic feed(input int n, input int gap);
    logic acc;
    int   g;
    for (int i = 0; i < n; i++) begin
      g = (i == 0) ? 0 : ((gap < 0) ? $urandom_range(0, 3) : gap);
      bus.wr_valid = 0;
      repeat (g) tick();
      bus.wr_valid = 1;
      bus.wr_data  = phrase[i];
      acc = 0;
      for (int k = 0; k < 50 && !acc; k++) begin
        @(negedge clock);
        acc = bus.wr_ready;
        tick();
      end
      chk("wr_accept", acc, 1);
    end
    bus.wr_valid = 0;
  endtask

  task automatic wait_done(input int limit);
    logic seen;
    seen = 0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clock);
      seen = bus.done;
      tick();
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic host_read(input logic [12:0] a, output logic [7:0] d);
    logic g;
    g = 0;
    bus.rd_req = 1; bus.rd_addr = a;
    for (int k = 0; k < 20 && !g; k++) begin
      @(negedge clock);
      g = bus.rd_grant;
      tick();
    end
    bus.rd_req = 0;
    chk("host_grant", g, 1);
    @(negedge clock);
    chk("host_rd_dv", bus.rd_data_valid, 1);
    d = bus.rd_data;
    tick();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin : main
    logic [7:0]  d;
    logic [12:0] a;
    logic [13:0] len;
    logic        op, g1;
    int          waited, g0, v0;

    reset_n = 0; mon_en = 0; traffic_en = 0;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
    bus.wr_valid = 0; bus.wr_data = 0;
    bus.vid_req = 0; bus.vid_addr = 0; bus.rd_req = 0; bus.rd_addr = 0;
    for (int i = 0; i < 64; i++) phrase[i] = 8'(i);

    // reset state
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_we", bus.ram_write_enable, 0);
    chk("rst_en", bus.ram_enable, 0);
    chk("rst_vdv", bus.vid_data_valid, 0);
    chk("rst_rdv", bus.rd_data_valid, 0);
    @(posedge clock); #1;
    reset_n = 1; mon_en = 1;
    @(negedge clock);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    tick();

    // phrase write, then host readback
    phrase[0] = 8'h48; phrase[1] = 8'h49; phrase[2] = 8'h21;
    issue_cmd(0, 13'h0010, 14'd3, waited);
    feed(3, 0);
    @(negedge clock);
    chk("t1_done", bus.done, 1);
    chk("t1_busy", bus.busy, 0);
    tick();
    host_read(13'h0010, d); chk("t1_rd10", d, 8'h48);
    host_read(13'h0011, d); chk("t1_rd11", d, 8'h49);
    host_read(13'h0012, d); chk("t1_rd12", d, 8'h21);

    // clear across the address wrap
    issue_cmd(1, 13'h1FFE, 14'd4, waited);
    wait_done(10);
    host_read(13'h1FFE, d); chk("t2_rd1ffe", d, CLEAR_VALUE);
    host_read(13'h1FFF, d); chk("t2_rd1fff", d, CLEAR_VALUE);
    host_read(13'h0000, d); chk("t2_rd0000", d, CLEAR_VALUE);
    host_read(13'h0001, d); chk("t2_rd0001", d, CLEAR_VALUE);
    host_read(13'h0002, d); chk("t2_rd0002", d, pat(2));

    // video starves host readback
    g0 = 0; v0 = vdv_count;
    for (int i = 0; i < 8; i++) begin
      bus.vid_req = 1; bus.vid_addr = 13'(i); bus.rd_req = 1; bus.rd_addr = 13'h0010;
      @(negedge clock);
      if (bus.rd_grant) g0++;
      tick();
    end
    bus.vid_req = 0;
    @(negedge clock);
    g1 = bus.rd_grant;
    tick();
    bus.rd_req = 0;
    @(negedge clock);
    tick();
    chk("t3_starved_grants", g0, 0);
    chk("t3_grant_after", g1, 1);
    chk("t3_vid_dv_count", vdv_count - v0, 8);

    // gapped phrase bytes
    phrase[0] = 8'hA5; phrase[1] = 8'h5A;
    issue_cmd(0, 13'h0020, 14'd2, waited);
    feed(2, 2);
    @(negedge clock);
    chk("t4_done", bus.done, 1);
    tick();
    host_read(13'h0020, d); chk("t4_rd20", d, 8'hA5);
    host_read(13'h0021, d); chk("t4_rd21", d, 8'h5A);
    host_read(13'h0022, d); chk("t4_rd22", d, pat(13'h0022));

    // zero-length command
    issue_cmd(0, 13'h0030, 14'd0, waited);
    @(negedge clock);
    chk("t5_done", bus.done, 1);
    chk("t5_we", bus.ram_write_enable, 0);
    chk("t5_ready", bus.cmd_ready, 1);
    tick();
    @(negedge clock);
    chk("t5_done_once", bus.done, 0);
    tick();

    // second command held off while busy
    issue_cmd(1, 13'h0100, 14'd20, waited);
    phrase[0] = 8'h11; phrase[1] = 8'h22;
    issue_cmd(0, 13'h0200, 14'd2, waited);
    chk("t5_held_off", waited, 20);
    feed(2, 0);
    wait_done(5);

    // reset in mid-clear
    issue_cmd(1, 13'h0400, 14'd100, waited);
    repeat (10) tick();
    mon_en = 0; reset_n = 0;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_we", bus.ram_write_enable, 0);
    chk("t6_en", bus.ram_enable, 0);
    repeat (2) tick();
    reset_n = 1; mon_en = 1;
    @(negedge clock);
    chk("t6_ready", bus.cmd_ready, 1);
    tick();
    host_read(13'h0409, d); chk("t6_rd409", d, CLEAR_VALUE);
    host_read(13'h040A, d); chk("t6_rd40a", d, pat(13'h040A));
    phrase[0] = 8'h77; phrase[1] = 8'h88;
    issue_cmd(0, 13'h0410, 14'd2, waited);
    feed(2, 0);
    wait_done(5);
    host_read(13'h0411, d); chk("t6_rd411", d, 8'h88);

    // random commands under random read traffic
    traffic_en = 1;
    repeat (30) begin
      op  = $urandom_range(0, 1) == 1;
      a   = rnd_addr();
      len = 14'($urandom_range(0, 24));
      for (int i = 0; i < 64; i++) phrase[i] = 8'($urandom);
      issue_cmd(op, a, len, waited);
      if (!op) feed(int'(len), -1);
      wait_done(200);
      repeat ($urandom_range(0, 3)) tick();
    end

    // clear longer than the RAM: every location rewritten
    issue_cmd(1, 13'h1FF0, 14'd8195, waited);
    wait_done(9000);
    traffic_off();
    tick();
    host_read(13'h1FF2, d); chk("t7_rd1ff2", d, CLEAR_VALUE);
    host_read(13'h0011, d); chk("t7_rd0011", d, CLEAR_VALUE);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phrase_ram_ctrl.md
Name: phrase_ram_ctrl

Overview:
Controller and arbiter for the 8192x8 phrase RAM (1-cycle registered read; separate write and read addresses; one shared enable). It accepts host commands that either stream a phrase into the RAM or clear an address range. It also arbitrates the RAM read port between the video character fetch (priority) and host readback.

Parameters:
ADDR_W, 13, RAM address width
DATA_W, 8, RAM data width
CLEAR_VALUE, 8'h00, byte written by clear commands

Ports:
clock  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  1  0 = write phrase, 1 = clear range
cmd_addr  in  ADDR_W  start address
cmd_len  in  ADDR_W+1  byte count
wr_valid  in  1  phrase byte valid
wr_ready  out  1  phrase byte accepted this cycle when wr_valid is also high
wr_data  in  DATA_W  phrase byte
busy  out  1  high in WRITE or CLEAR
done  out  1  one-cycle pulse when a command completes
vid_req  in  1  video read request, always served
vid_addr  in  ADDR_W  video read address
vid_data_valid  out  1  vid_data valid; one cycle after vid_req
vid_data  out  DATA_W  video read data
rd_req  in  1  host readback request, held until granted
rd_addr  in  ADDR_W  host read address
rd_grant  out  1  host read issued this cycle
rd_data_valid  out  1  rd_data valid; one cycle after rd_grant
rd_data  out  DATA_W  host read data
ram_enable  out  1  RAM enable
ram_write_enable  out  1  RAM write enable
ram_address_wr  out  ADDR_W  RAM write address
ram_address_rd  out  ADDR_W  RAM read address
ram_data_in  out  DATA_W  RAM write data
ram_data_out  in  DATA_W  RAM registered read data

Behaviour:
- Reset (async, reset_n=0): state is IDLE; busy, done, vid_data_valid, rd_data_valid, ram_enable and ram_write_enable are 0; cur_addr and remaining are 0; cmd_ready=1 after release.
- A reset in mid-command abandons the command with no done pulse. Bytes already written stay in the RAM.
- FSM states:
  - IDLE, with cmd_ready=1. A cmd_valid&cmd_ready handshake latches cur_addr=cmd_addr and remaining=cmd_len.
    - If cmd_len=0, stay in IDLE and pulse done on the next cycle. No RAM write occurs.
    - Otherwise go to WRITE (op=0) or CLEAR (op=1).
  - WRITE, with wr_ready=1. On each wr_valid cycle: write wr_data to cur_addr, cur_addr++, remaining--. The handshake that takes remaining to 0 returns to IDLE and sets done=1 on the next cycle.
  - CLEAR: write CLEAR_VALUE to cur_addr every cycle, with the same increment and termination rules as WRITE. A clear of N bytes takes exactly N cycles.
- cur_addr increments modulo 2^ADDR_W, so 8191 wraps to 0. A cmd_len above 8192 overwrites the wrapped locations again; no error is raised.
- Write port: ram_write_enable=1 only on a WRITE handshake or a CLEAR cycle. ram_address_wr=cur_addr. ram_data_in is wr_data or CLEAR_VALUE.
- Read arbitration (combinational, same cycle):
  - If vid_req=1, ram_address_rd=vid_addr.
  - Else if rd_req=1, ram_address_rd=rd_addr and rd_grant=1.
  - Otherwise ram_address_rd holds its previous value.
  - Video never stalls. The host is starved while vid_req is held.
- ram_enable = write this cycle OR vid_req OR rd_grant. When ram_enable=0 the RAM output holds.
- Read return:
  - vid_data_valid is registered from vid_req; rd_data_valid is registered from rd_grant.
  - vid_data and rd_data both equal ram_data_out.
  - Latency is exactly 1 cycle, with one read per cycle at full throughput.
- Reads and writes may occur in the same cycle. A read of the address being written that cycle returns the old byte; there is no forwarding.
- A command arriving while busy is not accepted (cmd_ready=0); the host holds cmd_valid.
- done is high for exactly one cycle per accepted command.

Test Plan:
- Reset, then write phrase addr=0x0010 len=3 with bytes 0x48,0x49,0x21 at one per cycle → three writes at 0x10..0x12, done pulses one cycle after the third byte, busy falls the same cycle. Host reads of 0x10..0x12 return 0x48,0x49,0x21, each with rd_data_valid one cycle after rd_grant.
- Clear addr=0x1FFE len=4 → writes CLEAR_VALUE to 0x1FFE,0x1FFF,0x0000,0x0001 in 4 consecutive cycles, then done. 0x0002 is unchanged.
- Hold vid_req with addresses 0..7 while rd_req is asserted → rd_grant stays 0 for 8 cycles and vid_data_valid is high for 8 cycles. rd_grant=1 on the first cycle vid_req=0.
- Write len=2 with wr_valid gaps (valid, idle, idle, valid) → exactly 2 writes and done after the second handshake. Bytes are not duplicated.
- cmd_len=0 → no ram_write_enable, done pulses once, cmd_ready stays 1. A second cmd_valid during busy is held off until the first command is done.
- reset_n pulled low mid-CLEAR of len=100 after 10 cycles → outputs go to 0 immediately with no done pulse. After release a new command is accepted.
